strobe_bank: RTL
================

# strobe_bank

Multi-channel, parametrised edge-strobe generator; the successor to the single-bit strobe used across the tracking and baseband control paths. Each channel optionally synchronises an asynchronous or cross-domain level, detects rising, falling or both edges under a run-time mode, and emits a one-cycle registered strobe. It also enforces an optional hold-off window, latches a sticky pending flag and keeps a saturating event count. It sits between raw status/timing levels (1PPS, accumulation-dump, TLM/HOW sync flags) and the per-channel control logic that consumes single-cycle events.

## Interface
- CHANNELS, 4: number of independent channels (≥1).
- SYNC_STAGES, 2: synchroniser flops per channel (0 = input used directly).
- HOLDOFF, 0: cycles after a strobe during which further edges on that channel are ignored (0 = none).
- CNT_WIDTH, 8: width of each per-channel event counter (≥1).
- RESET_PRIME, 1: 1 = suppress detection until the pipeline refills after reset; 0 = post-reset history is 0, so a high input produces a rising edge.

- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in  input  CHANNELS  raw levels, one bit per channel.
- mode  input  2*CHANNELS  per-channel mode, bits [2i+1:2i]: 00 disabled, 01 rising, 10 falling, 11 both.
- clear  input  CHANNELS  per-channel synchronous clear of pending and count.
- strobe  output  CHANNELS  registered one-cycle event pulse.
- pending  output  CHANNELS  sticky "event seen since last clear".
- count  output  CHANNELS*CNT_WIDTH  saturating event count, channel i at [i*CNT_WIDTH +: CNT_WIDTH].
- level  output  CHANNELS  synchronised level s[i] (in[i] when SYNC_STAGES=0).

## Operation
- Per channel: s = last synchroniser stage, or in[i] if SYNC_STAGES=0; p = s delayed one clk.
- Rise = s & ~p; fall = ~s & p. Qualified edge q = (mode bit0 & rise) | (mode bit1 & fall); mode 00 never qualifies.
- Hold-off: q is ignored while the channel's hold-off counter is nonzero. An accepted q loads the counter with HOLDOFF; it decrements by 1 per cycle to 0. Edges during hold-off are discarded, not deferred. p keeps tracking s regardless.
- Accepted q sets the strobe register for exactly one cycle, sets pending and increments count. Count saturates at 2^CNT_WIDTH−1 and does not wrap.
- clear[i] zeroes pending[i] and count[i]. With a simultaneous accepted event, the result is pending=1 and count=1 (event wins over clear). clear does not affect hold-off, synchroniser or strobe.
- RESET_PRIME=1: a per-block prime counter blocks every q for the first SYNC_STAGES+1 clk edges after reset deasserts. p then equals the true input level, so an input held high through reset gives no strobe.
- Mode changes take effect for the edge evaluated in the same cycle; they are not registered.
- Channels are fully independent; no shared arbitration.

## Timing
- Reset values: strobe=0, pending=0, count=0, level=0; all synchroniser, p, hold-off and prime registers = 0. Outputs go to 0 asynchronously on reset assertion, including mid-pulse or mid-hold-off.
- Latency: a new level captured at clk edge k (first synchroniser sample, or edge k itself when SYNC_STAGES=0) appears on strobe after edge k+SYNC_STAGES. That is SYNC_STAGES+1 edges total, and strobe is high for one cycle. pending and count update on the same edge as strobe.
- level follows in after SYNC_STAGES edges; with SYNC_STAGES=0 it is combinational.
- Minimum accepted strobe spacing: HOLDOFF+1 cycles. With HOLDOFF=0, both-edge mode and a toggling input, strobe can be high every cycle.
- An input pulse shorter than one clk may be missed; this is not an error.

## Test plan
- CHANNELS=4, SYNC_STAGES=2, mode=01 on ch0: in[0] 0→1 sampled at edge 10 -> strobe[0] high only after edge 12; pending[0]=1; count[0]=1; level[0] high after edge 11.
- mode=11, HOLDOFF=0, SYNC_STAGES=0: in[1] toggles every cycle for 10 cycles -> strobe[1] high for 10 consecutive cycles, count[1]=10. Repeat with mode=10 -> 5 strobes, count=5.
- HOLDOFF=3, mode=11: edges on in[2] at cycles 0,2,4,6 -> strobes for edges 0 and 4 only, count=2; edges 2 and 6 dropped.
- CNT_WIDTH=3: 9 rising edges -> count saturates at 7. clear with no event -> pending=0, count=0. clear coincident with a strobe -> pending=1, count=1.
- RESET_PRIME=1, in[3] held high through reset release -> no strobe over 10 cycles. With RESET_PRIME=0 -> one strobe at edge SYNC_STAGES+1 after release.
- Assert reset asynchronously mid-hold-off and while strobe=1 -> all outputs 0 before the next clk edge. After release, the first edge is detected without residual hold-off.

Source files
------------

// File: rtl/strobe_bank_if.sv
// Bundle of per-channel level inputs, mode/clear controls and event outputs for strobe_bank.
interface strobe_bank_if #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CNT_WIDTH = 8
);
  logic [CHANNELS-1:0]           in;
  logic [2*CHANNELS-1:0]         mode;
  logic [CHANNELS-1:0]           clear;
  logic [CHANNELS-1:0]           strobe;
  logic [CHANNELS-1:0]           pending;
  logic [CHANNELS*CNT_WIDTH-1:0] count;
  logic [CHANNELS-1:0]           level;

  // Consumer side: drives levels and controls, observes events.
  modport master (
    output in, mode, clear,
    input  strobe, pending, count, level
  );

  // Generator side.
  modport slave (
    input  in, mode, clear,
    output strobe, pending, count, level
  );
endinterface

// File: rtl/strobe_bank.sv
// Multi-channel edge-strobe generator: optional synchroniser, run-time edge select, hold-off
// window, one-cycle registered strobe, sticky pending flag and saturating event counter.
module strobe_bank #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLDOFF     = 0,
  parameter int unsigned CNT_WIDTH   = 8,
  parameter bit          RESET_PRIME = 1'b1
) (
  input logic         clk,
  input logic         reset,
  strobe_bank_if.slave bus
);
  localparam int unsigned HoW      = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam int unsigned PrimeMax = SYNC_STAGES + 1;
  localparam int unsigned PrW      = $clog2(PrimeMax + 1);
  localparam logic [HoW-1:0]       HoLoad = HoW'(HOLDOFF);
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  logic [CHANNELS-1:0]  s;          // synchronised level
  logic [CHANNELS-1:0]  p_q;        // s delayed one cycle
  logic [CHANNELS-1:0]  acc;        // qualified edge accepted this cycle
  logic [CHANNELS-1:0]  strobe_q;
  logic [CHANNELS-1:0]  pending_q;
  logic [HoW-1:0]       ho_q  [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_q [CHANNELS];
  logic                 primed;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = bus.in;
  end else begin : g_sync
    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];

    // Shift raw levels through the synchroniser chain.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
      end else begin
        sync_q[0] <= bus.in;
        for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      end
    end

    assign s = sync_q[SYNC_STAGES-1];
  end

  if (RESET_PRIME) begin : g_prime
    logic [PrW-1:0] prime_q;

    // Count edges after reset until the pipeline holds real input history.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        prime_q <= '0;
      end else if (prime_q != PrW'(PrimeMax)) begin
        prime_q <= prime_q + 1'b1;
      end
    end

    assign primed = (prime_q == PrW'(PrimeMax));
  end else begin : g_noprime
    assign primed = 1'b1;
  end

  // Edge qualification: mode bit0 selects rising, bit1 falling; hold-off discards edges.
  always_comb begin
    acc = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      acc[c] = primed && (ho_q[c] == '0) &&
               ((bus.mode[2*c] && s[c] && !p_q[c]) ||
                (bus.mode[2*c+1] && !s[c] && p_q[c]));
    end
  end

  // Edge history, strobe pulse and hold-off window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q      <= '0;
      strobe_q <= '0;
      for (int c = 0; c < int'(CHANNELS); c++) ho_q[c] <= '0;
    end else begin
      p_q      <= s;
      strobe_q <= acc;
      for (int c = 0; c < int'(CHANNELS); c++) begin
        if (acc[c]) begin
          ho_q[c] <= HoLoad;
        end else if (ho_q[c] != '0) begin
          ho_q[c] <= ho_q[c] - 1'b1;
        end
      end
    end
  end

  // Sticky pending and saturating count; an event in the same cycle as clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      for (int c = 0; c < int'(CHANNELS); c++) cnt_q[c] <= '0;
    end else begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        if (acc[c]) begin
          pending_q[c] <= 1'b1;
          if (bus.clear[c]) begin
            cnt_q[c] <= CntOne;
          end else if (cnt_q[c] != CntMax) begin
            cnt_q[c] <= cnt_q[c] + 1'b1;
          end
        end else if (bus.clear[c]) begin
          pending_q[c] <= 1'b0;
          cnt_q[c]     <= '0;
        end
      end
    end
  end

  for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_cnt_out
    assign bus.count[c*CNT_WIDTH +: CNT_WIDTH] = cnt_q[c];
  end

  assign bus.strobe  = strobe_q;
  assign bus.pending = pending_q;
  assign bus.level   = s;
endmodule
